wb_port_arbiter: RTL and testbench

- Controls the single register-file write port fed by the writeback stage.
- Arbitrates that port between the in-order pipeline result (ResultW) and completions from the multi-cycle unit (divider / long-latency load).
- Buffers multi-cycle results in a small FIFO and enforces write-after-write ordering by squashing stale entries.
- Stalls the W stage when a buffered result has waited too long.

---
 rtl/wb_port_arbiter_if.sv | 32 +++
 rtl/wb_port_arbiter.sv | 112 +++++++++++
 tb/tb_wb_port_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Writeback-port bundle: W-stage pipeline write, multi-cycle completion handshake,
// register-file write port and FIFO occupancy.
interface wb_port_arbiter_if #(
  parameter int WORD_SIZE  = 32,
  parameter int REG_ADDR_W = 5,
  parameter int FIFO_DEPTH = 2
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                  RegWriteW;
  logic [REG_ADDR_W-1:0] RdW;
  logic [WORD_SIZE-1:0]  ResultW;
  logic                  mc_valid;
  logic [REG_ADDR_W-1:0] mc_rd;
  logic [WORD_SIZE-1:0]  mc_data;
  logic                  mc_ready;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [WORD_SIZE-1:0]  rf_wdata;
  logic                  StallW;
  logic [CNT_W-1:0]      fifo_count;

  modport master (
    output RegWriteW, RdW, ResultW, mc_valid, mc_rd, mc_data,
    input  mc_ready, rf_we, rf_waddr, rf_wdata, StallW, fifo_count
  );

  modport slave (
    input  RegWriteW, RdW, ResultW, mc_valid, mc_rd, mc_data,
    output mc_ready, rf_we, rf_waddr, rf_wdata, StallW, fifo_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the in-order W stage and a
// small FIFO of multi-cycle results, squashing stale entries to keep WAW order.
module wb_port_arbiter #(
  parameter int WORD_SIZE  = 32,
  parameter int REG_ADDR_W = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic             clk,
  input  logic             rst,
  wb_port_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  FULL_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  logic [REG_ADDR_W-1:0] rdArr   [FIFO_DEPTH];
  logic [WORD_SIZE-1:0]  dataArr [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vldArr;
  logic [PTR_W-1:0]      rdPtr, wrPtr;
  logic [CNT_W-1:0]      count;
  logic [WAIT_W-1:0]     waitCnt;

  logic                  full, empty, headV, headDead, mcReady, pw, mw;
  logic                  forceDrain, squash, bypass, push, pop, waitInc;
  logic                  selWe, selStall;
  logic [REG_ADDR_W-1:0] selAddr;
  logic [WORD_SIZE-1:0]  selData;

  always_comb begin
    full       = (count == FULL_C);
    empty      = (count == '0);
    headV      = !empty && vldArr[rdPtr];
    headDead   = !empty && !vldArr[rdPtr];
    mcReady    = rst && !full;
    pw         = bus.RegWriteW && (bus.RdW != '0);
    mw         = bus.mc_valid && mcReady;
    forceDrain = headV && (waitCnt == MAX_WAIT_C);
    // The held W-stage instruction squashes when it finally writes, not while stalled.
    squash     = pw && !forceDrain;

    selWe    = 1'b0;
    selStall = 1'b0;
    selAddr  = '0;
    selData  = '0;
    bypass   = 1'b0;
    waitInc  = 1'b0;
    pop      = headDead;

    if (forceDrain) begin
      selWe    = 1'b1;
      selStall = 1'b1;
      selAddr  = rdArr[rdPtr];
      selData  = dataArr[rdPtr];
      pop      = 1'b1;
    end else if (pw) begin
      selWe   = 1'b1;
      selAddr = bus.RdW;
      selData = bus.ResultW;
      waitInc = headV;
    end else if (headV) begin
      selWe   = 1'b1;
      selAddr = rdArr[rdPtr];
      selData = dataArr[rdPtr];
      pop     = 1'b1;
    end else if (empty && mw && (bus.mc_rd != '0)) begin
      selWe   = 1'b1;
      selAddr = bus.mc_rd;
      selData = bus.mc_data;
      bypass  = 1'b1;
    end

    push = mw && (bus.mc_rd != '0) && !bypass && !(squash && (bus.mc_rd == bus.RdW));
  end

  assign bus.mc_ready   = mcReady;
  assign bus.rf_we      = rst && selWe;
  assign bus.rf_waddr   = rst ? selAddr : '0;
  assign bus.rf_wdata   = rst ? selData : '0;
  assign bus.StallW     = rst && selStall;
  assign bus.fifo_count = rst ? count : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr   <= '0;
      wrPtr   <= '0;
      count   <= '0;
      waitCnt <= '0;
      vldArr  <= '0;
    end else begin
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (push) wrPtr <= wrPtr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (pop)
        waitCnt <= '0;
      else if (waitInc && (waitCnt != MAX_WAIT_C))
        waitCnt <= waitCnt + 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++)
        if (squash && (rdArr[i] == bus.RdW)) vldArr[i] <= 1'b0;
      if (push) vldArr[wrPtr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rdArr[wrPtr]   <= bus.mc_rd;
      dataArr[wrPtr] <= bus.mc_data;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: expected register-file writes are queued in order and
// matched against every rf_we cycle; directed checks cover reset, stall and backpressure.
module tb_wb_port_arbiter;
  localparam int WORD_SIZE  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int FIFO_DEPTH = 2;
  localparam int MAX_WAIT   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.WORD_SIZE(WORD_SIZE), .REG_ADDR_W(REG_ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) bus();

  wb_port_arbiter #(
    .WORD_SIZE(WORD_SIZE), .REG_ADDR_W(REG_ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct { logic [4:0] rd; logic [31:0] data; } wrT;
  typedef struct { logic we; logic [4:0] rd; logic [31:0] data; } pipeT;
  typedef struct { int at; logic [4:0] rd; logic [31:0] data; } mcT;

  wrT   sbQ[$];
  pipeT pipeQ[$];
  mcT   mcQ[$];
  wrT   monExp;
  logic [31:0] shadow [32];
  int assertCnt = 0;
  int failCnt = 0;
  int stalls, maxCnt, nrCnt;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void addExp(input logic [4:0] rd, input logic [31:0] d);
    sbQ.push_back('{rd, d});
  endfunction

  function automatic void addPipe(input logic we, input logic [4:0] rd, input logic [31:0] d);
    pipeQ.push_back('{we, rd, d});
  endfunction

  function automatic void addMc(input int at, input logic [4:0] rd, input logic [31:0] d);
    mcQ.push_back('{at, rd, d});
  endfunction

  task automatic idleInputs();
    bus.RegWriteW = 1'b0;
    bus.RdW       = '0;
    bus.ResultW   = '0;
    bus.mc_valid  = 1'b0;
    bus.mc_rd     = '0;
    bus.mc_data   = '0;
  endtask

  // Every register-file write must match the next queued expectation.
  always @(negedge clk) begin
    if (bus.rf_we === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkVal("sbUnexpWr", 32'(sbQ.size()), 32'd1);
      end else begin
        monExp = sbQ.pop_front();
        checkVal("sbWaddr", 32'(bus.rf_waddr), 32'(monExp.rd));
        checkVal("sbWdata", bus.rf_wdata, monExp.data);
        shadow[bus.rf_waddr] = bus.rf_wdata;
      end
    end
  end

  // Presents queued W-stage and multi-cycle traffic, honouring StallW and mc_ready.
  task automatic runSeq(input int budget, input bit mustDrain,
                        output int st, output int mx, output int nr);
    int cyc;
    cyc = 0; st = 0; mx = 0; nr = 0;
    while ((pipeQ.size() != 0 || mcQ.size() != 0 || bus.fifo_count != '0) && cyc < budget) begin
      if (pipeQ.size() != 0) begin
        bus.RegWriteW = pipeQ[0].we;
        bus.RdW       = pipeQ[0].rd;
        bus.ResultW   = pipeQ[0].data;
      end else begin
        bus.RegWriteW = 1'b0;
      end
      if (mcQ.size() != 0 && mcQ[0].at <= cyc) begin
        bus.mc_valid = 1'b1;
        bus.mc_rd    = mcQ[0].rd;
        bus.mc_data  = mcQ[0].data;
      end else begin
        bus.mc_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.StallW) st++;
      if (int'(bus.fifo_count) > mx) mx = int'(bus.fifo_count);
      if (bus.mc_valid && !bus.mc_ready) nr++;
      if (bus.mc_valid && bus.mc_ready) mcQ.delete(0);
      if (pipeQ.size() != 0 && !bus.StallW) pipeQ.delete(0);
      @(posedge clk); #1;
      cyc++;
    end
    if (mustDrain) checkVal("drainBudget", 32'(cyc < budget), 32'd1);
    idleInputs();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    idleInputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("rstWe",    32'(bus.rf_we), 32'd0);
    checkVal("rstReady", 32'(bus.mc_ready), 32'd0);
    checkVal("rstCount", 32'(bus.fifo_count), 32'd0);
    checkVal("rstStall", 32'(bus.StallW), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkVal("relReady", 32'(bus.mc_ready), 32'd1);
    @(posedge clk); #1;

    // Plain pipeline write, then an x0 pipeline write
    addExp(5'd5, 32'h1234);
    bus.RegWriteW = 1'b1; bus.RdW = 5'd5; bus.ResultW = 32'h1234;
    @(negedge clk);
    checkVal("pwWe", 32'(bus.rf_we), 32'd1);
    @(posedge clk); #1;
    bus.RdW = 5'd0; bus.ResultW = 32'h999;
    @(negedge clk);
    checkVal("x0PipeWe", 32'(bus.rf_we), 32'd0);
    @(posedge clk); #1;

    // Bypass with empty FIFO, then an x0 multi-cycle result
    idleInputs();
    addExp(5'd7, 32'hAA);
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd7; bus.mc_data = 32'hAA;
    @(negedge clk);
    checkVal("bypWe", 32'(bus.rf_we), 32'd1);
    checkVal("bypCount", 32'(bus.fifo_count), 32'd0);
    @(posedge clk); #1;
    bus.mc_rd = 5'd0; bus.mc_data = 32'hBB;
    @(negedge clk);
    checkVal("bypCountAfter", 32'(bus.fifo_count), 32'd0);
    checkVal("x0McWe", 32'(bus.rf_we), 32'd0);
    checkVal("x0McReady", 32'(bus.mc_ready), 32'd1);
    @(posedge clk); #1;
    idleInputs();
    @(negedge clk);
    checkVal("x0McCount", 32'(bus.fifo_count), 32'd0);
    @(posedge clk); #1;

    // Starvation: head waits MAX_WAIT pipeline wins, then one forced drain
    for (int r = 9; r <= 14; r++) addPipe(1'b1, 5'(r), 32'h1000 + r);
    addMc(0, 5'd3, 32'hC003);
    for (int r = 9; r <= 13; r++) addExp(5'(r), 32'h1000 + r);
    addExp(5'd3, 32'hC003);
    addExp(5'd14, 32'h100E);
    runSeq(40, 1'b1, stalls, maxCnt, nrCnt);
    checkVal("t4Stalls", 32'(stalls), 32'd1);
    checkVal("t4MaxCount", 32'(maxCnt), 32'd1);

    // Backpressure: three results offered into a two-entry FIFO
    addPipe(1'b1, 5'd16, 32'h1010); addPipe(1'b1, 5'd17, 32'h1011);
    addPipe(1'b1, 5'd18, 32'h1012); addPipe(1'b1, 5'd19, 32'h1013);
    addPipe(1'b1, 5'd23, 32'h1017); addPipe(1'b1, 5'd24, 32'h1018);
    addMc(0, 5'd20, 32'hC014); addMc(0, 5'd21, 32'hC015); addMc(0, 5'd22, 32'hC016);
    addExp(5'd16, 32'h1010); addExp(5'd17, 32'h1011); addExp(5'd18, 32'h1012);
    addExp(5'd19, 32'h1013); addExp(5'd23, 32'h1017); addExp(5'd20, 32'hC014);
    addExp(5'd24, 32'h1018); addExp(5'd21, 32'hC015); addExp(5'd22, 32'hC016);
    runSeq(60, 1'b1, stalls, maxCnt, nrCnt);
    checkVal("t5Stalls", 32'(stalls), 32'd1);
    checkVal("t5MaxCount", 32'(maxCnt), 32'd2);
    checkVal("t5NotReady", 32'(nrCnt), 32'd4);

    // WAW: buffered r9 squashed by a younger pipeline write; same-cycle mc r9 discarded
    addPipe(1'b1, 5'd16, 32'h2010); addPipe(1'b1, 5'd9, 32'h55); addPipe(1'b0, 5'd0, 32'h0);
    addMc(0, 5'd9, 32'h99); addMc(1, 5'd9, 32'h77); addMc(2, 5'd12, 32'hC0C);
    addExp(5'd16, 32'h2010); addExp(5'd9, 32'h55); addExp(5'd12, 32'hC0C);
    runSeq(40, 1'b1, stalls, maxCnt, nrCnt);
    checkVal("t6R9", shadow[9], 32'h55);
    checkVal("t6MaxCount", 32'(maxCnt), 32'd1);
    checkVal("t6Stalls", 32'(stalls), 32'd0);

    // Reset asserted during a forced-drain stall with two entries buffered
    addPipe(1'b1, 5'd16, 32'h3010); addPipe(1'b1, 5'd17, 32'h3011);
    addPipe(1'b1, 5'd18, 32'h3012); addPipe(1'b1, 5'd19, 32'h3013);
    addPipe(1'b1, 5'd23, 32'h3017);
    addMc(0, 5'd20, 32'hD014); addMc(0, 5'd21, 32'hD015);
    addExp(5'd16, 32'h3010); addExp(5'd17, 32'h3011); addExp(5'd18, 32'h3012);
    addExp(5'd19, 32'h3013); addExp(5'd23, 32'h3017); addExp(5'd20, 32'hD014);
    runSeq(5, 1'b0, stalls, maxCnt, nrCnt);
    pipeQ.delete();
    mcQ.delete();
    bus.RegWriteW = 1'b1; bus.RdW = 5'd24; bus.ResultW = 32'h3018;
    @(negedge clk);
    checkVal("t1Stall", 32'(bus.StallW), 32'd1);
    checkVal("t1Count", 32'(bus.fifo_count), 32'd2);
    checkVal("t1Waddr", 32'(bus.rf_waddr), 32'd20);
    #1 rst = 1'b0;
    #1;
    checkVal("t1RstWe", 32'(bus.rf_we), 32'd0);
    checkVal("t1RstStall", 32'(bus.StallW), 32'd0);
    checkVal("t1RstReady", 32'(bus.mc_ready), 32'd0);
    checkVal("t1RstCount", 32'(bus.fifo_count), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    idleInputs();
    rst = 1'b1;
    @(negedge clk);
    checkVal("t1RelReady", 32'(bus.mc_ready), 32'd1);
    checkVal("t1RelCount", 32'(bus.fifo_count), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    checkVal("sbLeft", 32'(sbQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end
endmodule
